// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter in front of one shared external 32x32 signed multiplier.
// It latches the winner's operands, waits MUL_LAT edges, then returns the product to that requester.
module mul_rr_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                   slow_clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [32*N_REQ-1:0]    req_a,
  input  logic [32*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [63:0]            rsp_c,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [63:0]            mul_c,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 3;
  localparam int unsigned CW  = 4;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  win_idx;
  logic            win_found;
  logic [DW-1:0]   win_a;
  logic [DW-1:0]   win_b;
  logic            rsp_hit;

  // Round-robin search starting just after the last released requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(last_grant) + 32'd1 + k) % N_REQ);
      if (!win_found && |(req_valid & (ONE << cand))) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_a = DW'(req_a >> {win_idx, 5'd0});
    win_b = DW'(req_b >> {win_idx, 5'd0});
  end

  assign req_ready = (state == IDLE && win_found) ? (ONE << win_idx) : '0;
  assign rsp_hit   = |(rsp_ready & (ONE << grant_id));

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_c      <= '0;
      rsp_valid  <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      last_grant <= IDW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            mul_a    <= win_a;
            mul_b    <= win_b;
            grant_id <= win_idx;
            cnt      <= CW'(MUL_LAT);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Product is valid on mul_c by the edge where cnt reaches 1.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_c     <= mul_c;
            rsp_valid <= ONE << grant_id;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_hit) begin
            last_grant <= grant_id;
            rsp_valid  <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter: three instances (MUL_LAT 2, 1, 15), each fed by a
// pipelined multiplier model with matching latency so a mistimed capture returns a stale product.
module tb_mul_rr_arbiter;

  logic         slow_clk;
  logic         rst;

  // Main instance, MUL_LAT = 2
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [63:0]  rsp_c, mul_c;
  logic [31:0]  mul_a, mul_b;
  logic [2:0]   grant_id;
  logic         busy;

  // Latency instances share their inputs
  logic [3:0]   req_valid_x, rsp_ready_x;
  logic [127:0] req_a_x, req_b_x;
  logic [3:0]   req_ready1, rsp_valid1, req_ready15, rsp_valid15;
  logic [63:0]  rsp_c1, mul_c1, rsp_c15, mul_c15;
  logic [31:0]  mul_a1, mul_b1, mul_a15, mul_b15;
  logic [2:0]   grant_id1, grant_id15;
  logic         busy1, busy15;

  int total = 0;
  int bad   = 0;

  logic [31:0] ra [4];
  logic [31:0] rb [4];
  logic [63:0] exp_c;

  mul_rr_arbiter #(.N_REQ(4), .MUL_LAT(2)) dut (
    .slow_clk(slow_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .grant_id(grant_id), .busy(busy)
  );

  mul_rr_arbiter #(.N_REQ(4), .MUL_LAT(1)) dut1 (
    .slow_clk(slow_clk), .rst(rst), .req_valid(req_valid_x), .req_ready(req_ready1),
    .req_a(req_a_x), .req_b(req_b_x), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready_x),
    .rsp_c(rsp_c1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_c(mul_c1),
    .grant_id(grant_id1), .busy(busy1)
  );

  mul_rr_arbiter #(.N_REQ(4), .MUL_LAT(15)) dut15 (
    .slow_clk(slow_clk), .rst(rst), .req_valid(req_valid_x), .req_ready(req_ready15),
    .req_a(req_a_x), .req_b(req_b_x), .rsp_valid(rsp_valid15), .rsp_ready(rsp_ready_x),
    .rsp_c(rsp_c15), .mul_a(mul_a15), .mul_b(mul_b15), .mul_c(mul_c15),
    .grant_id(grant_id15), .busy(busy15)
  );

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Multiplier models: latency L means L-1 register stages after the operand registers.
  logic [63:0] pipe2;
  logic [63:0] pipe15 [14];
  always_ff @(posedge slow_clk) begin
    pipe2     <= prod(mul_a, mul_b);
    pipe15[0] <= prod(mul_a15, mul_b15);
    for (int k = 1; k < 14; k++) pipe15[k] <= pipe15[k-1];
  end
  assign mul_c   = pipe2;
  assign mul_c1  = prod(mul_a1, mul_b1);
  assign mul_c15 = pipe15[13];

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on the main instance with rsp_ready high for the winner.
  task automatic run_op(input int idx, input logic [63:0] exp_p, input string tag);
    logic [3:0] oh;
    oh = 4'(1) << idx;
    #1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(oh));
    tick();
    chk({tag, ".grant_id"}, 64'(grant_id), 64'(idx));
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    chk({tag, ".ready_wait"}, 64'(req_ready), 64'(0));
    chk({tag, ".valid_e0"}, 64'(rsp_valid), 64'(0));
    tick();
    chk({tag, ".valid_e1"}, 64'(rsp_valid), 64'(0));
    tick();
    chk({tag, ".valid_e2"}, 64'(rsp_valid), 64'(oh));
    chk({tag, ".rsp_c"}, rsp_c, exp_p);
    tick();
    chk({tag, ".valid_rel"}, 64'(rsp_valid), 64'(0));
    chk({tag, ".busy_rel"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    rsp_ready   = 4'b1111;
    req_a       = '0;
    req_b       = '0;
    req_valid_x = '0;
    rsp_ready_x = '0;
    req_a_x     = '0;
    req_b_x     = '0;
    ra[0] = 32'd5;        rb[0] = 32'd9;
    ra[1] = 32'hFFFFFFFE; rb[1] = 32'd11;
    ra[2] = 32'h12345678; rb[2] = 32'hFFFFFFF9;
    ra[3] = 32'd100000;   rb[3] = 32'd300000;

    // Reset state
    #1;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.grant_id", 64'(grant_id), 64'(0));
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst.rsp_c", rsp_c, 64'(0));
    chk("rst.mul_a", 64'(mul_a), 64'(0));
    chk("rst.req_ready", 64'(req_ready), 64'(0));
    #22;
    rst = 1'b0;

    // 7 * -3 on requester 0
    req_a[31:0] = 32'd7;
    req_b[31:0] = 32'hFFFFFFFD;
    req_valid   = 4'b0001;
    run_op(0, 64'hFFFFFFFFFFFFFFEB, "basic");

    // Reset pulse while an operation is in WAIT
    req_a[31:0] = 32'd11;
    req_b[31:0] = 32'd13;
    tick();
    chk("wrst.busy_pre", 64'(busy), 64'(1));
    tick();
    #2;
    rst       = 1'b1;
    req_valid = '0;
    #1;
    chk("wrst.busy", 64'(busy), 64'(0));
    chk("wrst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("wrst.mul_a", 64'(mul_a), 64'(0));
    chk("wrst.mul_b", 64'(mul_b), 64'(0));
    chk("wrst.rsp_c", rsp_c, 64'(0));
    chk("wrst.grant_id", 64'(grant_id), 64'(0));
    #2;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("wrst.no_rsp", 64'(rsp_valid), 64'(0));
    end

    // All four valid: rotation 0,1,2,3,0 starting from requester 0
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = ra[i];
      req_b[32*i +: 32] = rb[i];
    end
    req_valid = 4'b1111;
    run_op(0, prod(ra[0], rb[0]), "rot0");
    run_op(1, prod(ra[1], rb[1]), "rot1");
    run_op(2, prod(ra[2], rb[2]), "rot2");
    run_op(3, prod(ra[3], rb[3]), "rot3");
    run_op(0, prod(ra[0], rb[0]), "rot4");

    // Requester 1 stalls its response for 5 cycles; other rsp_ready bits stay high
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    #1;
    chk("hold.req_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = 4'b1111;
    tick();
    tick();
    exp_c = prod(ra[1], rb[1]);
    chk("hold.valid0", 64'(rsp_valid), 64'(4'b0010));
    chk("hold.rsp_c0", rsp_c, exp_c);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("hold.valid", 64'(rsp_valid), 64'(4'b0010));
      chk("hold.rsp_c", rsp_c, exp_c);
      chk("hold.req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 4'b1111;
    req_valid = 4'b0000;
    tick();
    chk("hold.release", 64'(rsp_valid), 64'(0));
    chk("hold.busy", 64'(busy), 64'(0));

    // Sign corner cases
    req_a[31:0]  = 32'h80000000;
    req_b[31:0]  = 32'h80000000;
    req_valid    = 4'b0001;
    run_op(0, 64'h4000000000000000, "minsq");
    req_a[127:96] = 32'hFFFFFFFF;
    req_b[127:96] = 32'd1;
    req_valid     = 4'b1000;
    run_op(3, 64'hFFFFFFFFFFFFFFFF, "neg1");
    req_valid = 4'b0000;

    // Capture latency for MUL_LAT = 1 and 15
    req_a_x[31:0] = 32'd3;
    req_b_x[31:0] = 32'hFFFFFFFB;
    req_valid_x   = 4'b0001;
    #1;
    chk("lat.ready1", 64'(req_ready1), 64'(4'b0001));
    chk("lat.ready15", 64'(req_ready15), 64'(4'b0001));
    tick();
    req_valid_x = 4'b0000;
    chk("lat.grant1", 64'(grant_id1), 64'(0));
    chk("lat.grant15", 64'(grant_id15), 64'(0));
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk("lat.valid1", 64'(rsp_valid1), 64'(4'b0001));
      chk("lat.valid15", 64'(rsp_valid15), (t == 15) ? 64'(4'b0001) : 64'(0));
    end
    chk("lat.rsp_c1", rsp_c1, 64'hFFFFFFFFFFFFFFF1);
    chk("lat.rsp_c15", rsp_c15, 64'hFFFFFFFFFFFFFFF1);
    rsp_ready_x = 4'b1111;
    tick();
    chk("lat.busy1", 64'(busy1), 64'(0));
    chk("lat.busy15", 64'(busy15), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_rr_arbiter.md
MUL_RR_ARBITER -- requirements
Module: mul_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MUL_LAT, default 2, slow_clk edges from operand launch to valid mul_c (1..15).
REQ-003 SHALL have port slow_clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operand-valid.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept strobe.
REQ-007 SHALL have port req_a  input  32*N_REQ  signed multiplicand, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_b  input  32*N_REQ  signed multiplier, same packing as req_a.
REQ-009 SHALL have port rsp_valid  output  N_REQ  result-valid, at most one bit set.
REQ-010 SHALL have port rsp_ready  input  N_REQ  per-requester result-accept.
REQ-011 SHALL have port rsp_c  output  64  shared signed product bus.
REQ-012 SHALL have port mul_a, mul_b  output  32 each  registered operands driving the shared 32x32 signed multiplier.
REQ-013 SHALL have port mul_c  input  64  multiplier product.
REQ-014 SHALL have port grant_id  output  3  index of current/last granted requester.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE, req_ready SHALL be a combinational one-hot of the winning valid requester, searched round-robin starting at (last_grant+1) mod N_REQ; all-zero if no req_valid.
REQ-018 At a slow_clk edge in IDLE with any req_valid: winner's req_a/req_b loaded into mul_a/mul_b, grant_id <= winner, cnt <= MUL_LAT, state <= WAIT.
REQ-019 In WAIT each edge: cnt == 1 -> rsp_c <= mul_c, state <= RESP; otherwise cnt <= cnt-1.
REQ-020 Product captured exactly MUL_LAT edges after the accept edge; rsp_valid visible from that edge.
REQ-021 In RESP, rsp_valid[grant_id] SHALL be 1, all other bits 0; rsp_c held stable.
REQ-022 At an edge in RESP with rsp_ready[grant_id]: last_grant <= grant_id, state <= IDLE; rsp_ready on other bits ignored.
REQ-023 mul_a/mul_b SHALL hold until the next accept; rsp_c holds until the next capture.
REQ-024 req_ready SHALL be 0 in WAIT and RESP; req_valid dropped before acceptance is legal and not remembered.
REQ-025 rsp_c SHALL equal mul_c bit-for-bit; no sign or width manipulation in this block.
REQ-026 Min service period per operation SHALL be MUL_LAT+2 edges (accept, MUL_LAT-1 waits, capture-to-RESP, release).
REQ-027 With all N_REQ requesters continuously valid, grants SHALL rotate 0,1,...,N_REQ-1,0 with no starvation.
REQ-028 With rsp_ready held high, RESP SHALL last exactly one cycle.

Reset
REQ-029 rst SHALL immediately force state IDLE, cnt 0, mul_a/mul_b 0, rsp_c 0, rsp_valid 0, grant_id 0, busy 0, last_grant N_REQ-1 (requester 0 has first priority).
REQ-030 rst mid-WAIT or mid-RESP SHALL discard the in-flight operation; no rsp_valid after deassertion.
REQ-031 First arbitration SHALL occur at the first slow_clk edge after rst deasserts.

Verification
REQ-032 Req0 a=7, b=-3, MUL_LAT=2, rsp_ready=1 -> req_ready[0] in IDLE; rsp_valid[0] after edge +2; rsp_c=0xFFFFFFFFFFFFFFEB.
REQ-033 All four valid, distinct operands, rsp_ready=1 -> grants 0,1,2,3,0; each rsp_c correct; rsp_valid one-hot.
REQ-034 rsp_ready[1] held low 5 cycles in RESP for req1 -> rsp_valid[1] and rsp_c stable 5 cycles; req_ready all 0.
REQ-035 rst pulse during WAIT -> all outputs 0 immediately; no response emitted; next request by req0 wins.
REQ-036 a=0x80000000, b=0x80000000 -> rsp_c=0x4000000000000000; a=-1, b=1 -> rsp_c=0xFFFFFFFFFFFFFFFF.
REQ-037 MUL_LAT=1 and MUL_LAT=15 -> capture exactly 1 / 15 edges after accept.
